neander_agu: RTL and testbench
==============================

# neander_agu

Parametrised address-generation unit for the next NEANDER core. It replaces the fixed single X register, the SP register and the in-line `rem + x` adder with one block. The block holds NUM_IDX index registers and a bounded stack pointer. It computes a registered effective address per request, with post-increment, pre-decrement, stack-relative, push and pop modes. It also detects stack overflow and underflow. It sits between the control unit and the REM/memory address path.

## Interface
Parameters:
- DATA_W, 8, index register width
- ADDR_W, 8, address width; DATA_W <= ADDR_W
- NUM_IDX, 2, number of index registers (X=0, Y=1, ...), >= 1
- SEL_W, max(1, clog2(NUM_IDX)), index select width
- STACK_BASE, all ones (ADDR_W), SP reset value and empty-stack value
- STACK_FLOOR, 2**(ADDR_W-1), lowest legal SP value (full-stack value)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  address request
- req_ready  out  1  block can accept a request
- req_mode  in  3  000 direct, 001 base+idx, 010 base+idx post-inc, 011 base+idx pre-dec, 100 push, 101 pop, 110 base+SP, 111 reserved
- req_base  in  ADDR_W  base address (operand byte)
- req_sel  in  SEL_W  index register used by modes 001-011
- ea_valid  out  1  one-cycle pulse: ea is valid
- ea  out  ADDR_W  effective address
- ea_wrap  out  1  carry out of the address add for the request shown on ea
- wr_en / wr_sel / wr_data  in  1 / SEL_W / DATA_W  explicit index load (LDX, LDXI, TAX)
- inc_en / inc_sel  in  1 / SEL_W  explicit index increment (INX)
- sp_load / sp_data  in  1 / ADDR_W  explicit SP load
- rd_sel  in  SEL_W  index read select
- rd_data  out  DATA_W  combinational value of idx[rd_sel] (TXA, STX)
- sp_value  out  ADDR_W  current SP
- stk_ovf / stk_unf  out  1 / 1  sticky fault flags
- fault  out  1  one-cycle pulse on a faulting push or pop
- flag_clr  in  1  clears both sticky flags and leaves the FAULT state

## Operation
- Accept a request when req_valid && req_ready.
- FSM states are IDLE and FAULT.
  - IDLE: req_ready = 1.
  - FAULT: req_ready = 0. Requests are ignored. Explicit writes still work.
  - FAULT -> IDLE on flag_clr.
- EA per mode (idx zero-extended to ADDR_W; all adds modulo 2^ADDR_W; ea_wrap = carry; ea_wrap = 0 for modes 000, 100, 101, 111):
  - 000 and 111: ea = base.
  - 001: ea = base + idx.
  - 010: ea = base + idx; then idx <= idx + 1 (mod 2^DATA_W).
  - 011: idx <= idx - 1; ea = base + (idx - 1).
  - 100 push: if SP == STACK_FLOOR it is a fault. Otherwise SP <= SP-1 and ea = SP-1.
  - 101 pop: if SP == STACK_BASE it is a fault. Otherwise ea = SP and SP <= SP+1.
  - 110: ea = base + SP.
- Fault behaviour:
  - SP is unchanged and there is no ea_valid.
  - fault pulses.
  - stk_ovf is set (push) or stk_unf is set (pop).
  - The FSM enters FAULT.
- Same-cycle conflicts on one index register: wr_en > request side effect > inc_en. The losing updates are dropped.
- Same-cycle conflicts on SP: sp_load beats push/pop. The EA of that request still uses the pre-load SP. No fault check is made against sp_data.
- The request EA always uses register values from before the edge; a same-cycle wr_en does not bypass into it.
- flag_clr in the same cycle as a new fault: the set wins; the flag stays 1 and the FSM stays in FAULT.
- There is no wrap protection on idx inc/dec: 0xFF+1 = 0x00 and 0x00-1 = 0xFF.

## Timing
- Reset values:
  - idx[*] = 0, SP = STACK_BASE, state = IDLE.
  - ea = 0, ea_valid = 0, ea_wrap = 0, fault = 0, stk_ovf = 0, stk_unf = 0.
  - req_ready = 1 as soon as reset_n is released.
- Reset is asynchronous. Asserting it mid-request clears ea_valid and fault immediately, and the pending side effect is lost.
- Latency:
  - ea, ea_wrap and ea_valid are registered, 1 cycle after acceptance.
  - Back-to-back requests are supported, one per cycle, with ea_valid high on consecutive cycles.
- Register and SP updates from a request, wr_en, inc_en or sp_load are visible on rd_data and sp_value the cycle after the edge.
- fault pulses in the same cycle the result would have appeared. req_ready is low from that cycle.

## Test plan
- Reset, then mode 001, base 0x20, idx0 = 0x05 (via wr_en) -> next cycle ea = 0x25, ea_valid = 1, ea_wrap = 0.
- idx1 = 0xFF, mode 010, base 0x02, sel 1 -> ea = 0x01, ea_wrap = 1. Then rd_data(sel 1) = 0x00.
- From reset, push twice -> ea = 0xFE, 0xFD; SP = 0xFD. Then pop twice -> ea = 0xFD, 0xFE; SP = 0xFF. A third pop -> fault pulse, stk_unf = 1, req_ready = 0, no ea_valid. flag_clr -> req_ready = 1.
- sp_load 0x80, then push -> stk_ovf = 1, SP stays 0x80. A request in FAULT is ignored and wr_en still updates idx0.
- Same cycle: wr_en idx0 = 0x10, mode 010 on idx0 (old 0x03), inc_en idx0 -> ea = base + 0x03, then idx0 = 0x10.
- Assert reset_n low during an accepted push -> ea_valid = 0 immediately. After release, SP = 0xFF.

Source files
------------

// File: rtl/neander_agu.sv
// neander_agu: index registers, bounded stack pointer and registered effective-address generation
module neander_agu #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NUM_IDX = 2,
  parameter int SEL_W = NUM_IDX > 1 ? $clog2(NUM_IDX) : 1,
  parameter logic [ADDR_W-1:0] STACK_BASE = '1,
  parameter logic [ADDR_W-1:0] STACK_FLOOR = {1'b1, {(ADDR_W-1){1'b0}}}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_mode,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [SEL_W-1:0]  req_sel,
  output logic              ea_valid,
  output logic [ADDR_W-1:0] ea,
  output logic              ea_wrap,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              inc_en,
  input  logic [SEL_W-1:0]  inc_sel,
  input  logic              sp_load,
  input  logic [ADDR_W-1:0] sp_data,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] sp_value,
  output logic              stk_ovf,
  output logic              stk_unf,
  output logic              fault,
  input  logic              flag_clr
);
  typedef enum logic {IDLE, FAULT} state_t;
  state_t state, state_nxt;
  logic [DATA_W-1:0] idx [NUM_IDX];
  logic [ADDR_W-1:0] sp;
  logic accept, push, pop, push_f, pop_f, bad, go;
  logic [DATA_W-1:0] idx_cur, idx_dec;
  logic [ADDR_W-1:0] add_a, add_b;
  logic [ADDR_W:0] sum;
  // Request decode: one shared adder covers every mode; push/pop use a zero addend so their carry is 0
  always_comb begin
    accept = req_valid && req_ready;
    push = accept && req_mode == 3'b100;
    pop = accept && req_mode == 3'b101;
    push_f = push && sp == STACK_FLOOR;
    pop_f = pop && sp == STACK_BASE;
    bad = push_f || pop_f;
    go = accept && !bad;
    idx_cur = idx[req_sel];
    idx_dec = idx_cur - DATA_W'(1);
    add_a = push ? sp - ADDR_W'(1) : pop ? sp : req_base;
    add_b = (req_mode == 3'b001 || req_mode == 3'b010) ? ADDR_W'(idx_cur) :
            req_mode == 3'b011 ? ADDR_W'(idx_dec) :
            req_mode == 3'b110 ? sp : '0;
    sum = {1'b0, add_a} + {1'b0, add_b};
  end
  // State register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  // Next state: a new fault outranks a same-cycle flag_clr
  always_comb
    state_nxt = bad ? FAULT : (state == FAULT && flag_clr) ? IDLE : state;
  // Outputs decoded from state
  always_comb
    req_ready = state == IDLE;
  // Registered effective address, fault pulse and sticky flags
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ea <= '0;
      ea_valid <= 1'b0;
      ea_wrap <= 1'b0;
      fault <= 1'b0;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
    end else begin
      ea_valid <= go;
      fault <= bad;
      stk_ovf <= push_f || (stk_ovf && !flag_clr);
      stk_unf <= pop_f || (stk_unf && !flag_clr);
      if (go) begin
        ea <= sum[ADDR_W-1:0];
        ea_wrap <= sum[ADDR_W];
      end
    end
  // Stack pointer: explicit load beats push/pop movement
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sp <= STACK_BASE;
    else sp <= sp_load ? sp_data : (go && push) ? sp - ADDR_W'(1) : (go && pop) ? sp + ADDR_W'(1) : sp;
  // Index registers: explicit write > request side effect > explicit increment
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) for (int i = 0; i < NUM_IDX; i++) idx[i] <= '0;
    else for (int i = 0; i < NUM_IDX; i++)
      idx[i] <= (wr_en && wr_sel == SEL_W'(i)) ? wr_data :
                (go && req_sel == SEL_W'(i) && req_mode == 3'b010) ? idx[i] + DATA_W'(1) :
                (go && req_sel == SEL_W'(i) && req_mode == 3'b011) ? idx[i] - DATA_W'(1) :
                (inc_en && inc_sel == SEL_W'(i)) ? idx[i] + DATA_W'(1) : idx[i];
  assign rd_data = idx[rd_sel];
  assign sp_value = sp;
endmodule

// File: tb/tb_neander_agu.sv
// tb_neander_agu: directed vector table plus randomized traffic against a reference model
module tb_neander_agu;
  logic clk = 1'b0, reset_n = 1'b0;
  logic req_valid, req_ready, ea_valid, ea_wrap, wr_en, inc_en, sp_load;
  logic stk_ovf, stk_unf, fault, flag_clr;
  logic [2:0] req_mode;
  logic [7:0] req_base, ea, wr_data, sp_data, rd_data, sp_value;
  logic req_sel, wr_sel, inc_sel, rd_sel;
  int n_checks = 0, n_fail = 0;
  int m_idx [2];
  int m_sp;
  bit m_ovf, m_unf, m_flt;

  typedef struct {
    logic rv; logic [2:0] mode; logic [7:0] base; logic sel;
    logic we; logic ws; logic [7:0] wd; logic ie; logic is;
    logic sl; logic [7:0] sd; logic fc; logic rs;
  } in_t;
  typedef struct {
    logic v; logic [7:0] ea; logic w; logic f; logic [7:0] sp;
    logic rdy; logic [7:0] rd; logic ovf; logic unf;
  } exp_t;
  typedef struct { in_t i; exp_t e; } vec_t;
  vec_t tab[$];

  neander_agu dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_base(req_base), .req_sel(req_sel), .ea_valid(ea_valid),
    .ea(ea), .ea_wrap(ea_wrap), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .inc_en(inc_en), .inc_sel(inc_sel), .sp_load(sp_load), .sp_data(sp_data),
    .rd_sel(rd_sel), .rd_data(rd_data), .sp_value(sp_value), .stk_ovf(stk_ovf),
    .stk_unf(stk_unf), .fault(fault), .flag_clr(flag_clr)
  );

  always #5 clk = ~clk;

  function automatic in_t mk(logic rv, logic [2:0] mode, logic [7:0] base, logic sel,
                             logic we, logic ws, logic [7:0] wd, logic ie, logic is,
                             logic sl, logic [7:0] sd, logic fc, logic rs);
    in_t r;
    r.rv = rv; r.mode = mode; r.base = base; r.sel = sel; r.we = we; r.ws = ws; r.wd = wd;
    r.ie = ie; r.is = is; r.sl = sl; r.sd = sd; r.fc = fc; r.rs = rs;
    return r;
  endfunction

  function automatic exp_t ex(logic v, logic [7:0] e, logic w, logic f, logic [7:0] sp,
                              logic rdy, logic [7:0] rd, logic ovf, logic unf);
    exp_t r;
    r.v = v; r.ea = e; r.w = w; r.f = f; r.sp = sp; r.rdy = rdy; r.rd = rd; r.ovf = ovf; r.unf = unf;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idx[0] = 0; m_idx[1] = 0; m_sp = 255; m_ovf = 0; m_unf = 0; m_flt = 0;
  endtask

  task automatic drive(input in_t v);
    req_valid = v.rv; req_mode = v.mode; req_base = v.base; req_sel = v.sel;
    wr_en = v.we; wr_sel = v.ws; wr_data = v.wd; inc_en = v.ie; inc_sel = v.is;
    sp_load = v.sl; sp_data = v.sd; flag_clr = v.fc; rd_sel = v.rs;
  endtask

  // One clock: model predicts from the pre-edge state, DUT is sampled 1 time unit after the edge
  task automatic step(input in_t v, input bit use_tab, input exp_t t);
    int e_v = 0, e_ea = 0, e_w = 0, s = 0;
    int b = v.base, ix = m_idx[v.sel], nsp = m_sp;
    int old0 = m_idx[0], old1 = m_idx[1];
    bit acc = v.rv && !m_flt, pf = 0, uf = 0;
    drive(v);
    if (acc)
      case (v.mode)
        3'd0, 3'd7: begin e_v = 1; e_ea = b; end
        3'd1, 3'd2: begin s = b + ix; e_v = 1; e_ea = s % 256; e_w = s / 256; end
        3'd3: begin s = b + (ix + 255) % 256; e_v = 1; e_ea = s % 256; e_w = s / 256; end
        3'd4: if (m_sp == 128) pf = 1; else begin e_v = 1; e_ea = (m_sp + 255) % 256; nsp = e_ea; end
        3'd5: if (m_sp == 255) uf = 1; else begin e_v = 1; e_ea = m_sp; nsp = (m_sp + 1) % 256; end
        default: begin s = b + m_sp; e_v = 1; e_ea = s % 256; e_w = s / 256; end
      endcase
    if (v.ie) m_idx[v.is] = ((v.is ? old1 : old0) + 1) % 256;
    if (acc && v.mode == 3'd2) m_idx[v.sel] = (ix + 1) % 256;
    if (acc && v.mode == 3'd3) m_idx[v.sel] = (ix + 255) % 256;
    if (v.we) m_idx[v.ws] = v.wd;
    if (v.sl) nsp = v.sd;
    m_sp = nsp;
    m_ovf = (m_ovf && !v.fc) || pf;
    m_unf = (m_unf && !v.fc) || uf;
    if (v.fc) m_flt = 0;
    if (pf || uf) m_flt = 1;
    @(posedge clk); #1;
    check("model ea_valid", ea_valid, e_v);
    if (e_v) begin
      check("model ea", ea, e_ea);
      check("model ea_wrap", ea_wrap, e_w);
    end
    check("model fault", fault, pf || uf);
    check("model sp", sp_value, m_sp);
    check("model ready", req_ready, !m_flt);
    check("model rd_data", rd_data, m_idx[v.rs]);
    check("model stk_ovf", stk_ovf, m_ovf);
    check("model stk_unf", stk_unf, m_unf);
    if (use_tab) begin
      check("tab ea_valid", ea_valid, t.v);
      if (t.v) begin
        check("tab ea", ea, t.ea);
        check("tab ea_wrap", ea_wrap, t.w);
      end
      check("tab fault", fault, t.f);
      check("tab sp", sp_value, t.sp);
      check("tab ready", req_ready, t.rdy);
      check("tab rd_data", rd_data, t.rd);
      check("tab stk_ovf", stk_ovf, t.ovf);
      check("tab stk_unf", stk_unf, t.unf);
    end
  endtask

  initial begin
    in_t r;
    exp_t nx;
    nx = ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // rv mode base sel | we ws wd | ie is | sl sd | fc rs  ->  v ea w f sp rdy rd ovf unf
    tab.push_back('{mk(0,0,8'h00,0, 1,0,8'h05, 0,0, 0,8'h00, 0,0), ex(0,8'h00,0,0,8'hFF,1,8'h05,0,0)});
    tab.push_back('{mk(1,1,8'h20,0, 0,0,8'h00, 0,0, 0,8'h00, 0,0), ex(1,8'h25,0,0,8'hFF,1,8'h05,0,0)});
    tab.push_back('{mk(0,0,8'h00,0, 1,1,8'hFF, 0,0, 0,8'h00, 0,1), ex(0,8'h00,0,0,8'hFF,1,8'hFF,0,0)});
    tab.push_back('{mk(1,2,8'h02,1, 0,0,8'h00, 0,0, 0,8'h00, 0,1), ex(1,8'h01,1,0,8'hFF,1,8'h00,0,0)});
    tab.push_back('{mk(1,4,8'h00,0, 0,0,8'h00, 0,0, 0,8'h00, 0,0), ex(1,8'hFE,0,0,8'hFE,1,8'h05,0,0)});
    tab.push_back('{mk(1,4,8'h00,0, 0,0,8'h00, 0,0, 0,8'h00, 0,0), ex(1,8'hFD,0,0,8'hFD,1,8'h05,0,0)});
    tab.push_back('{mk(1,5,8'h00,0, 0,0,8'h00, 0,0, 0,8'h00, 0,0), ex(1,8'hFD,0,0,8'hFE,1,8'h05,0,0)});
    tab.push_back('{mk(1,5,8'h00,0, 0,0,8'h00, 0,0, 0,8'h00, 0,0), ex(1,8'hFE,0,0,8'hFF,1,8'h05,0,0)});
    tab.push_back('{mk(1,5,8'h00,0, 0,0,8'h00, 0,0, 0,8'h00, 0,0), ex(0,8'h00,0,1,8'hFF,0,8'h05,0,1)});
    tab.push_back('{mk(1,1,8'h20,0, 0,0,8'h00, 0,0, 0,8'h00, 0,0), ex(0,8'h00,0,0,8'hFF,0,8'h05,0,1)});
    tab.push_back('{mk(0,0,8'h00,0, 0,0,8'h00, 0,0, 0,8'h00, 1,0), ex(0,8'h00,0,0,8'hFF,1,8'h05,0,0)});
    tab.push_back('{mk(0,0,8'h00,0, 0,0,8'h00, 0,0, 1,8'h80, 0,0), ex(0,8'h00,0,0,8'h80,1,8'h05,0,0)});
    tab.push_back('{mk(1,4,8'h00,0, 0,0,8'h00, 0,0, 0,8'h00, 0,0), ex(0,8'h00,0,1,8'h80,0,8'h05,1,0)});
    tab.push_back('{mk(1,1,8'h33,0, 1,0,8'h03, 0,0, 0,8'h00, 0,0), ex(0,8'h00,0,0,8'h80,0,8'h03,1,0)});
    tab.push_back('{mk(0,0,8'h00,0, 0,0,8'h00, 0,0, 0,8'h00, 1,0), ex(0,8'h00,0,0,8'h80,1,8'h03,0,0)});
    tab.push_back('{mk(1,2,8'h40,0, 1,0,8'h10, 1,0, 0,8'h00, 0,0), ex(1,8'h43,0,0,8'h80,1,8'h10,0,0)});
    tab.push_back('{mk(1,3,8'hF5,0, 0,0,8'h00, 0,0, 0,8'h00, 0,0), ex(1,8'h04,1,0,8'h80,1,8'h0F,0,0)});
    tab.push_back('{mk(1,6,8'h90,0, 0,0,8'h00, 0,0, 0,8'h00, 0,0), ex(1,8'h10,1,0,8'h80,1,8'h0F,0,0)});
    tab.push_back('{mk(1,0,8'hAB,0, 0,0,8'h00, 0,0, 0,8'h00, 0,0), ex(1,8'hAB,0,0,8'h80,1,8'h0F,0,0)});
    tab.push_back('{mk(1,7,8'h5C,0, 0,0,8'h00, 0,0, 0,8'h00, 0,0), ex(1,8'h5C,0,0,8'h80,1,8'h0F,0,0)});
    tab.push_back('{mk(0,0,8'h00,0, 0,0,8'h00, 0,0, 1,8'hA0, 0,0), ex(0,8'h00,0,0,8'hA0,1,8'h0F,0,0)});
    tab.push_back('{mk(1,4,8'h00,0, 0,0,8'h00, 0,0, 1,8'h50, 0,0), ex(1,8'h9F,0,0,8'h50,1,8'h0F,0,0)});
    tab.push_back('{mk(0,0,8'h00,0, 0,0,8'h00, 1,1, 0,8'h00, 0,1), ex(0,8'h00,0,0,8'h50,1,8'h01,0,0)});
    tab.push_back('{mk(1,3,8'h00,1, 0,0,8'h00, 0,0, 0,8'h00, 0,1), ex(1,8'h00,0,0,8'h50,1,8'h00,0,0)});
    tab.push_back('{mk(1,3,8'h01,1, 0,0,8'h00, 0,0, 0,8'h00, 0,1), ex(1,8'h00,1,0,8'h50,1,8'hFF,0,0)});
    tab.push_back('{mk(0,0,8'h00,0, 0,0,8'h00, 0,0, 1,8'h80, 0,1), ex(0,8'h00,0,0,8'h80,1,8'hFF,0,0)});
    tab.push_back('{mk(1,4,8'h00,0, 0,0,8'h00, 0,0, 0,8'h00, 1,1), ex(0,8'h00,0,1,8'h80,0,8'hFF,1,0)});
    tab.push_back('{mk(0,0,8'h00,0, 0,0,8'h00, 0,0, 0,8'h00, 1,1), ex(0,8'h00,0,0,8'h80,1,8'hFF,0,0)});

    drive(mk(0,0,0,0, 0,0,0, 0,0, 0,0, 0,0));
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    check("reset ea_valid", ea_valid, 0);
    check("reset ea", ea, 0);
    check("reset ea_wrap", ea_wrap, 0);
    check("reset fault", fault, 0);
    check("reset stk_ovf", stk_ovf, 0);
    check("reset stk_unf", stk_unf, 0);
    check("reset ready", req_ready, 1);
    check("reset sp", sp_value, 8'hFF);
    check("reset idx0", rd_data, 0);
    rd_sel = 1'b1; #1;
    check("reset idx1", rd_data, 0);

    foreach (tab[k]) step(tab[k].i, 1'b1, tab[k].e);

    for (int n = 0; n < 400; n++) begin
      r = mk($urandom_range(0, 9) < 7, 3'($urandom), 8'($urandom), 1'($urandom),
             $urandom_range(0, 9) < 1, 1'($urandom), 8'($urandom),
             $urandom_range(0, 9) < 2, 1'($urandom),
             $urandom_range(0, 19) < 1, 8'($urandom_range(8'h80, 8'hFF)),
             $urandom_range(0, 9) < 1, 1'($urandom));
      step(r, 1'b0, nx);
    end

    step(mk(0,0,8'h00,0, 0,0,8'h00, 0,0, 1,8'hFF, 1,0), 1'b0, nx);
    step(mk(1,4,8'h00,0, 0,0,8'h00, 0,0, 0,8'h00, 0,0), 1'b0, nx);
    #2 reset_n = 1'b0;
    #1;
    check("async reset ea_valid", ea_valid, 0);
    check("async reset fault", fault, 0);
    check("async reset sp", sp_value, 8'hFF);
    check("async reset ready", req_ready, 1);
    req_valid = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check("post reset sp", sp_value, 8'hFF);
    check("post reset ea_valid", ea_valid, 0);
    step(mk(1,4,8'h00,0, 0,0,8'h00, 0,0, 0,8'h00, 0,0), 1'b1, ex(1,8'hFE,0,0,8'hFE,1,8'h00,0,0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
